// File: rtl/dm_arbiter.sv
// dm_arbiter: lets a host port (debug loader / DMA) share the single-port data SRAM with the CPU.
// The CPU always has priority. A host request is latched and then served in the first cycle
// with no CPU access. Latency is two edges minimum. There is no CPU backpressure, and the host waits on h_busy.
// Ports: clock/reset (async active-low); cpu_* data port (cpu_rdata passes straight through from the RAM);
//        h_* host request/ack port with a saturating wait counter; ram_* to the SRAM,
//        which is clocked on the inverted clock, so ram_rdata updates at the falling edge.
// Optional: define DM_ARB_STAT_EN to add the stat_grants/stat_blocked wrapping counters.
module dm_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int WAIT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [AW-1:0]     h_addr,
  input  logic [DW-1:0]     h_wdata,
  output logic              h_busy,
  output logic              h_ack,
  output logic [DW-1:0]     h_rdata,
  output logic [WAIT_W-1:0] h_wait,
`ifdef DM_ARB_STAT_EN
  output logic [15:0]       stat_grants,
  output logic [15:0]       stat_blocked,
`endif
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  typedef enum logic {IDLE, PEND} state_e;

  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

  state_e              state_q, state_d;
  logic                hwe_q, hwe_d;
  logic [AW-1:0]       haddr_q, haddr_d;
  logic [DW-1:0]       hwdata_q, hwdata_d;
  logic                ack_q, ack_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic cpu_act;
  logic cpu_in_window;
  logic slot;

  assign cpu_act       = cpu_re | cpu_we;
  // CPU addresses above the RAM window (for example the end-of-sim marker) must never write the RAM.
  assign cpu_in_window = (cpu_addr[15:AW] == '0);
  assign slot          = (state_q == PEND) && !cpu_act;

  assign cpu_rdata = ram_rdata;
  assign h_busy    = (state_q == PEND);
  assign h_ack     = ack_q;
  assign h_rdata   = rdata_q;
  assign h_wait    = wait_q;

  // RAM mux. The CPU owns the port whenever it is active; otherwise a pending host access uses it.
  always_comb begin
    ram_addr  = cpu_addr[AW-1:0];
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    if (cpu_act) begin
      ram_we = cpu_we & cpu_in_window;
    end else if (state_q == PEND) begin
      ram_addr  = haddr_q;
      ram_wdata = hwdata_q;
      ram_we    = hwe_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    hwe_d    = hwe_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    wait_d   = wait_q;
    unique case (state_q)
      IDLE: begin
        if (h_req) begin
          hwe_d    = h_we;
          haddr_d  = h_addr;
          hwdata_d = h_wdata;
          wait_d   = '0;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (!cpu_act) begin
          // The RAM read completed at the falling edge inside the slot, so ram_rdata is valid here.
          ack_d   = 1'b1;
          state_d = IDLE;
          if (!hwe_q) rdata_d = ram_rdata;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hwe_q    <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      hwe_q    <= hwe_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
    end
  end

`ifdef DM_ARB_STAT_EN
  logic [15:0] grants_q, grants_d;
  logic [15:0] blocked_q, blocked_d;

  always_comb begin
    grants_d  = grants_q;
    blocked_d = blocked_q;
    if (slot) grants_d = grants_q + 16'd1;
    if ((state_q == PEND) && cpu_act) blocked_d = blocked_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grants_q  <= '0;
      blocked_q <= '0;
    end else begin
      grants_q  <= grants_d;
      blocked_q <= blocked_d;
    end
  end

  assign stat_grants  = grants_q;
  assign stat_blocked = blocked_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed scenarios followed by a randomized mix.
// A transaction-level reference model tracks the pending host request and a shadow copy of RAM.
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int WAIT_W = 8;
  localparam int DEPTH = 1 << AW;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [15:0]       cpu_addr = '0;
  logic              cpu_re = 1'b0;
  logic              cpu_we = 1'b0;
  logic [DW-1:0]     cpu_wdata = '0;
  logic [DW-1:0]     cpu_rdata;
  logic              h_req = 1'b0;
  logic              h_we = 1'b0;
  logic [AW-1:0]     h_addr = '0;
  logic [DW-1:0]     h_wdata = '0;
  logic              h_busy;
  logic              h_ack;
  logic [DW-1:0]     h_rdata;
  logic [WAIT_W-1:0] h_wait;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata = '0;
`ifdef DM_ARB_STAT_EN
  logic [15:0]       stat_grants;
  logic [15:0]       stat_blocked;
`endif

  dm_arbiter #(.AW(AW), .DW(DW), .WAIT_W(WAIT_W)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_busy(h_busy), .h_ack(h_ack), .h_rdata(h_rdata), .h_wait(h_wait),
`ifdef DM_ARB_STAT_EN
    .stat_grants(stat_grants), .stat_blocked(stat_blocked),
`endif
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // Data RAM on the inverted clock. It is preloaded with a known pattern at the first falling edge.
  logic [DW-1:0] ram [DEPTH];
  logic          ram_ready = 1'b0;
  always @(negedge clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i * 7 + 3);
      ram_ready <= 1'b1;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  // Reference model: shadow memory plus the one outstanding host request.
  int mem [DEPTH];
  bit m_pend;
  bit m_hwe;
  int m_haddr;
  int m_hwdata;
  int m_wait;
  bit m_ack;
  int m_rdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("h_busy", 32'(h_busy), 32'(m_pend));
    chk("h_ack", 32'(h_ack), 32'(m_ack));
    chk("h_rdata", 32'(h_rdata), 32'(m_rdata));
    chk("h_wait", 32'(h_wait), 32'(m_wait));
  endtask

  // Inputs are set by the caller at posedge+1. This task checks the RAM port mid-cycle,
  // advances one clock edge, and then checks the registered host outputs.
  task automatic cycle();
    bit act;
    int ea;
    bit ewe;
    int ewd;
    #2;
    act = cpu_re | cpu_we;
    if (act) begin
      ea  = int'(cpu_addr) % DEPTH;
      ewe = cpu_we && (int'(cpu_addr) < DEPTH);
      ewd = int'(cpu_wdata);
    end else if (m_pend && reset) begin
      ea  = m_haddr;
      ewe = m_hwe;
      ewd = m_hwdata;
    end else begin
      ea  = int'(cpu_addr) % DEPTH;
      ewe = 1'b0;
      ewd = -1;
    end
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    if (ewd >= 0) chk("ram_wdata", 32'(ram_wdata), 32'(ewd));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(ram_rdata));
    if (ewe) mem[ea] = ewd;
    @(posedge clock);
    #1;
    if (!reset) begin
      m_pend = 1'b0; m_ack = 1'b0; m_wait = 0; m_rdata = 0;
    end else if (m_pend && !act) begin
      m_ack  = 1'b1;
      m_pend = 1'b0;
      if (!m_hwe) m_rdata = mem[m_haddr];
    end else if (m_pend) begin
      m_ack  = 1'b0;
      m_wait = (m_wait + 1 > 255) ? 255 : m_wait + 1;
    end else begin
      m_ack = 1'b0;
      if (h_req) begin
        m_pend = 1'b1; m_hwe = h_we; m_haddr = int'(h_addr);
        m_hwdata = int'(h_wdata); m_wait = 0;
      end
    end
    check_regs();
  endtask

  task automatic cpu_idle();
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic host(input bit req, input bit we, input int addr, input int data);
    h_req = req; h_we = we; h_addr = AW'(addr); h_wdata = DW'(data);
  endtask

  initial begin
    int acks;
    int bad;
    int r;
`ifdef DM_ARB_STAT_EN
    int g0;
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = (i * 7 + 3) & 8'hFF;
    m_pend = 0; m_hwe = 0; m_haddr = 0; m_hwdata = 0; m_wait = 0; m_ack = 0; m_rdata = 0;

    // Reset state
    #1;
    chk("rst_busy", 32'(h_busy), 32'd0);
    chk("rst_ack", 32'(h_ack), 32'd0);
    chk("rst_rdata", 32'(h_rdata), 32'd0);
    chk("rst_wait", 32'(h_wait), 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    cycle();

    // Host write while the CPU is idle: two edges to ack, zero wait
    cpu_idle();
    host(1, 1, 'h010, 'hA5);
    cycle();
    chk("t1_busy", 32'(h_busy), 32'd1);
    host(0, 0, 0, 0);
    cycle();
    chk("t1_ack", 32'(h_ack), 32'd1);
    chk("t1_wait", 32'(h_wait), 32'd0);
    cycle();
    chk("t1_ram", 32'(ram['h010]), 32'hA5);

    // Host read delayed by five CPU reads
    host(1, 0, 'h010, 0);
    cycle();
    host(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cpu_re = 1'b1; cpu_addr = 16'(i + 'h40);
      cycle();
    end
    cpu_idle();
    cycle();
    chk("t2_ack", 32'(h_ack), 32'd1);
    chk("t2_rdata", 32'(h_rdata), 32'hA5);
    chk("t2_wait", 32'(h_wait), 32'd5);

    // Out-of-window CPU write still occupies the slot
    host(1, 1, 'h020, 'h3C);
    cycle();
    host(0, 0, 0, 0);
    cpu_we = 1'b1; cpu_addr = 16'hFEFF; cpu_wdata = 8'hFF;
    cycle();
    chk("t3_deferred", 32'(h_busy), 32'd1);
    cpu_idle();
    cycle();
    chk("t3_ack", 32'(h_ack), 32'd1);
    cycle();
    chk("t3_ram", 32'(ram['h020]), 32'h3C);

    // Request held high: one host access every two cycles
`ifdef DM_ARB_STAT_EN
    g0 = int'(stat_grants);
`endif
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      host(1, 1, 'h100 + i, 'h50 + i);
      cycle();
      if (h_ack) acks++;
    end
    host(0, 0, 0, 0);
    chk("t4_acks", 32'(acks), 32'd4);
`ifdef DM_ARB_STAT_EN
    chk("t4_grants", 32'(int'(stat_grants) - g0), 32'd4);
`endif
    cycle();

    // Continuous CPU activity saturates the wait counter
    host(1, 0, 'h100, 0);
    cycle();
    host(0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cpu_re = 1'b1; cpu_addr = 16'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    chk("t5_wait_sat", 32'(h_wait), 32'd255);
    chk("t5_no_ack", 32'(h_ack), 32'd0);
    cpu_idle();
    cycle();
    chk("t5_ack", 32'(h_ack), 32'd1);
    chk("t5_rdata", 32'(h_rdata), 32'h50);

    // Reset while a host write is pending drops it silently
    cycle();
    host(1, 1, 'h030, 'h77);
    cycle();
    host(0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("t6_busy", 32'(h_busy), 32'd0);
    chk("t6_ack", 32'(h_ack), 32'd0);
    chk("t6_wait", 32'(h_wait), 32'd0);
    m_pend = 1'b0; m_ack = 1'b0; m_wait = 0; m_rdata = 0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk("t6_ram_kept", 32'(ram['h030]), 32'(mem['h030]));
    host(1, 1, 'h031, 'h99);
    cycle();
    host(0, 0, 0, 0);
    cycle();
    chk("t6_new_ack", 32'(h_ack), 32'd1);
    cycle();
    chk("t6_new_ram", 32'(ram['h031]), 32'h99);

    // Randomized mix
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      cpu_re = 1'b0; cpu_we = 1'b0;
      cpu_wdata = 8'($urandom);
      if (r < 4) cpu_addr = 16'($urandom_range(0, 63));
      else if (r < 7) begin cpu_re = 1'b1; cpu_addr = 16'($urandom_range(0, 63)); end
      else if (r < 9) begin cpu_we = 1'b1; cpu_addr = 16'($urandom_range(0, 63)); end
      else begin cpu_we = 1'b1; cpu_addr = 16'($urandom_range(DEPTH, 16'hFFFF)); end
      host($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
      cycle();
    end
    cpu_idle();
    host(0, 0, 0, 0);
    cycle();
    cycle();
    cycle();

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (int'(ram[i]) != mem[i]) bad++;
    chk("ram_contents", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Shares the single-port data SRAM between the CPU data port and a secondary host port (debug loader / DMA).
- The CPU has no wait input, so it always has absolute priority.
- Host accesses are latched and slotted into cycles where the CPU issues no data access.
- Sits between CPU dm_* pins and the data RAM, whose clock is the inverted system clock.

Parameters:
AW, 10, RAM address width (RAM depth 2**AW words)
DW, 8, data width
WAIT_W, 8, width of the host wait-cycle counter (saturating)

Ports:
clock  input  1  master clock, rising edge
reset  input  1  asynchronous reset, active-low
cpu_addr  input  16  CPU data address
cpu_re  input  1  CPU read enable
cpu_we  input  1  CPU write enable
cpu_wdata  input  DW  CPU write data
cpu_rdata  output  DW  CPU read data (pass-through of ram_rdata)
h_req  input  1  host request, level-sampled
h_we  input  1  host write (1) / read (0)
h_addr  input  AW  host address
h_wdata  input  DW  host write data
h_busy  output  1  request latched, not yet served
h_ack  output  1  one-cycle completion pulse
h_rdata  output  DW  host read data, valid when h_ack=1, held until the next ack
h_wait  output  WAIT_W  cycles the current/last request waited, saturating
ram_addr  output  AW  to RAM
ram_we  output  1  to RAM
ram_wdata  output  DW  to RAM
ram_rdata  input  DW  from RAM (updated on falling clock edge)

Behaviour:
- Reset (reset=0, async): state IDLE; h_busy=0, h_ack=0, h_rdata=0, h_wait=0, latched host regs cleared. A pending host request is dropped and no ack is issued.
- cpu_act = cpu_re | cpu_we.
- FSM has two states: IDLE, PEND.
- IDLE: at a rising edge with h_req=1, latch h_we/h_addr/h_wdata, clear h_wait, go to PEND.
- PEND: h_busy=1; h_req is ignored.
  - If cpu_act=0 in a cycle, that cycle is the host slot. RAM is driven combinationally from the latched regs.
  - At the slot's closing rising edge: h_ack=1 for one cycle, h_rdata<=ram_rdata (reads only; writes leave h_rdata unchanged), go to IDLE.
  - If cpu_act=1: stay in PEND and h_wait increments, saturating at 2**WAIT_W-1.
- Minimum latency: h_req sampled at edge N, slot in cycle N..N+1, h_ack high in cycle after edge N+1 (2 edges).
- Back-to-back: in the ack cycle state is IDLE, so h_req=1 there is accepted. Sustained host throughput is one access per 2 cycles.
- RAM mux, combinational:
  - cpu_act=1: ram_addr=cpu_addr[AW-1:0], ram_wdata=cpu_wdata, ram_we = cpu_we & (cpu_addr[15:AW]==0).
  - else if PEND: host latched values, ram_we=latched h_we.
  - else: ram_addr=cpu_addr[AW-1:0], ram_we=0.
- Out-of-window CPU writes (e.g. the 0xFEFF end-of-sim marker) never reach the RAM, but they still occupy the slot.
- cpu_rdata=ram_rdata always; CPU timing is identical to a direct RAM connection.
- Simultaneous CPU write and host write to the same address: the CPU write happens and the host write is deferred. The host write lands later and wins.

Optional Feature:
Macro DM_ARB_STAT_EN.
- Defined: adds outputs stat_grants[15:0] (host slots served) and stat_blocked[15:0] (cycles in PEND with cpu_act=1). Both are wrapping counters, cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- CPU idle, host write h_addr=0x010 h_wdata=0xA5 -> ram_we=1 one cycle later, h_ack 2 edges after request, RAM[0x010]=0xA5, h_wait=0.
- CPU read loop for 5 cycles while host read of 0x010 is pending -> no RAM access by host during CPU cycles; h_ack on first idle cycle, h_rdata=0xA5, h_wait=5.
- CPU writes 0xFF to 0xFEFF -> ram_we=0 and the pending host access is still deferred that cycle.
- Host h_req held high for 4 consecutive accesses, CPU idle -> 4 h_ack pulses on alternating cycles; with DM_ARB_STAT_EN, stat_grants=4.
- CPU active continuously for 300 cycles with host pending -> h_wait saturates at 255; no ack until CPU idles.
- Assert reset low while PEND -> h_busy=0 immediately, no h_ack, RAM unchanged; a new request after release is served normally.
